// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : game_pkg                                                 |
// | Purpose   : Shared board geometry defaults, turn FSM state encoding  |
// |             and the dice LFSR step function for game_turn_ctrl.      |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package game_pkg;

  // Board geometry defaults, in pixels
  localparam int unsigned c_tile_spacing = 60;
  localparam int unsigned c_start_x      = 20;
  localparam int unsigned c_max_x        = 620;

  // Dice LFSR seed; any nonzero value keeps the maximal sequence alive
  localparam logic [7:0] c_lfsr_seed = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ROLL      = 3'd1,
    ST_UPDATE    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_NEXT      = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1 (period 255)
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_turn_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : game_turn_ctrl_if                                        |
// | Purpose   : Player position / turn status bus from the turn          |
// |             controller (master) to the renderer (slave).             |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface game_turn_ctrl_if;

  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic [1:0] dice_value;
  logic       game_over;
  logic       winner;

  modport master (
    output player1_pos_x, player2_pos_x, pos_valid, active_player,
           dice_value, game_over, winner
  );

  modport slave (
    input  player1_pos_x, player2_pos_x, pos_valid, active_player,
           dice_value, game_over, winner
  );

endinterface
`default_nettype wire

// File: rtl/game_turn_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : btn_debounce                                             |
// | Purpose   : Synchronises a raw push button, requires it to hold a    |
// |             new level for DEBOUNCE_CYCLES clocks, and emits a        |
// |             one-cycle pulse on each debounced rising edge.           |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  wire  clk_100mhz,
  input  wire  btn_reset,
  input  wire  i_btn,
  output logic o_rise
);

  localparam int unsigned c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_meta;
  logic               r_sync;
  logic               r_stable;
  logic               r_stable_d;
  logic [c_cnt_w-1:0] r_cnt;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end

  // Accept a new level only after it has differed from the held level for the full window
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_stable_d <= r_stable;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_stable & ~r_stable_d;

endmodule
`default_nettype wire

// File: rtl/game_turn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : game_turn_ctrl                                           |
// | Purpose   : Two-player dice race turn controller. A debounced roll   |
// |             press draws a 1..3 die from a free-running LFSR, moves   |
// |             the active player (clamped at the flag), strobes         |
// |             pos_valid, waits for the renderer's turn_done, then      |
// |             either hands over the turn or declares the winner.       |
// | Options   : TURN_TIMEOUT_EN - leave WAIT_DONE after TIMEOUT_CYCLES   |
// |             even without turn_done (absent by default).              |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TILE_SPACING    = c_tile_spacing,
  parameter int unsigned START_X         = c_start_x,
  parameter int unsigned MAX_X           = c_max_x,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned VALID_STRETCH   = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 100_000_000
) (
  input  wire              clk_100mhz,
  input  wire              btn_reset,
  input  wire              btn_roll,
  input  wire              turn_done,
  game_turn_ctrl_if.master bus
);

  localparam int unsigned c_stretch_w = (VALID_STRETCH > 1) ? $clog2(VALID_STRETCH) : 1;
  localparam logic [c_stretch_w-1:0] c_stretch_last = c_stretch_w'(VALID_STRETCH - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_pos_valid;
  logic                   w_roll_rise;
  logic                   w_done_rise;
  logic                   w_timeout;
  logic                   r_done_meta;
  logic                   r_done_sync;
  logic                   r_done_prev;
  logic [7:0]             r_lfsr;
  logic [c_stretch_w-1:0] r_stretch_cnt;
  logic [9:0]             r_p1_pos;
  logic [9:0]             r_p2_pos;
  logic                   r_active;
  logic [1:0]             r_dice;
  logic                   r_game_over;
  logic                   r_winner;
  logic [9:0]             w_active_pos;
  logic [1:0]             w_roll_dice;
  logic [10:0]            w_sum;
  logic [9:0]             w_new_pos;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_roll_debounce (
    .clk_100mhz (clk_100mhz),
    .btn_reset  (btn_reset),
    .i_btn      (btn_roll),
    .o_rise     (w_roll_rise)
  );

  // Bring turn_done over from the 25 MHz renderer domain and keep one extra stage for edge detection
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_done_meta <= 1'b0;
      r_done_sync <= 1'b0;
      r_done_prev <= 1'b0;
    end else begin
      r_done_meta <= turn_done;
      r_done_sync <= r_done_meta;
      r_done_prev <= r_done_sync;
    end
  end

  assign w_done_rise = r_done_sync & ~r_done_prev;

  // Free-running dice source; the draw depends on when the player presses
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_lfsr <= c_lfsr_seed;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned c_to_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [c_to_w-1:0] r_to_cnt;

  // Count cycles spent waiting for the renderer; restarts on every entry to WAIT_DONE
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_WAIT_DONE) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != c_to_last) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_WAIT_DONE) && (r_to_cnt == c_to_last);
`else
  assign w_timeout = 1'b0;
`endif

  // Move arithmetic: 11 bits so the overshoot past the flag is visible before clamping
  assign w_active_pos = r_active ? r_p2_pos : r_p1_pos;
  assign w_roll_dice  = 2'(r_lfsr % 8'd3) + 2'd1;
  assign w_sum        = {1'b0, w_active_pos} + (11'(w_roll_dice) * 11'(TILE_SPACING));
  assign w_new_pos    = (w_sum > 11'(MAX_X)) ? 10'(MAX_X) : w_sum[9:0];

  // Turn FSM state register
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; pos_valid decodes straight from the state so reset removes it at once
  always_comb begin
    w_state_next = r_state;
    w_pos_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_roll_rise) w_state_next = ST_ROLL;
      end
      ST_ROLL: begin
        w_state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_pos_valid = 1'b1;
        if (r_stretch_cnt == c_stretch_last) w_state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_done_rise || w_timeout) w_state_next = ST_NEXT;
      end
      ST_NEXT: begin
        w_state_next = (w_active_pos == 10'(MAX_X)) ? ST_GAME_OVER : ST_IDLE;
      end
      ST_GAME_OVER: begin
        w_state_next = ST_GAME_OVER;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Length of the pos_valid strobe
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_stretch_cnt <= '0;
    end else if (r_state == ST_UPDATE) begin
      r_stretch_cnt <= r_stretch_cnt + 1'b1;
    end else begin
      r_stretch_cnt <= '0;
    end
  end

  // Game state; the new position is written on the way into UPDATE so it is already stable on the first strobe cycle
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_p1_pos    <= 10'(START_X);
      r_p2_pos    <= 10'(START_X);
      r_active    <= 1'b0;
      r_dice      <= 2'd1;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
    end else begin
      case (r_state)
        ST_ROLL: begin
          r_dice <= w_roll_dice;
          if (r_active) r_p2_pos <= w_new_pos;
          else          r_p1_pos <= w_new_pos;
        end
        ST_NEXT: begin
          if (w_active_pos == 10'(MAX_X)) begin
            r_game_over <= 1'b1;
            r_winner    <= r_active;
          end else begin
            r_active <= ~r_active;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.player1_pos_x = r_p1_pos;
  assign bus.player2_pos_x = r_p2_pos;
  assign bus.pos_valid     = w_pos_valid;
  assign bus.active_player = r_active;
  assign bus.dice_value    = r_dice;
  assign bus.game_over     = r_game_over;
  assign bus.winner        = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_game_turn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_game_turn_ctrl                                        |
// | Purpose   : Scoreboard bench for game_turn_ctrl. Rolls are timed so  |
// |             an independent LFSR model yields the wanted die; each    |
// |             roll queues its expected positions and a monitor checks  |
// |             every pos_valid strobe against the queue.                |
// | Options   : TURN_TIMEOUT_EN enables the WAIT_DONE timeout scenario.  |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_game_turn_ctrl;

  typedef struct packed {
    logic [9:0] p1;
    logic [9:0] p2;
    logic       act;
    logic [1:0] dice;
  } exp_t;

  logic clk_100mhz = 1'b0;
  logic btn_reset  = 1'b0;
  logic btn_roll   = 1'b0;
  logic turn_done  = 1'b0;

  game_turn_ctrl_if bus ();

  game_turn_ctrl #(
    .TILE_SPACING    (60),
    .START_X         (20),
    .MAX_X           (620),
    .DEBOUNCE_CYCLES (4),
    .VALID_STRETCH   (4),
    .TIMEOUT_CYCLES  (50)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .btn_reset  (btn_reset),
    .btn_roll   (btn_roll),
    .turn_done  (turn_done),
    .bus        (bus)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  exp_t exp_q[$];
  int   n_pass   = 0;
  int   n_checks = 0;
  int   n_rises  = 0;
  bit   abort_ok = 1'b0;

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Reference dice source: x^8+x^6+x^5+x^4+1, seed A5, steps every clock out of reset
  function automatic logic [7:0] tb_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [7:0] m_lfsr;
  always @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) m_lfsr <= 8'hA5;
    else           m_lfsr <= tb_step(m_lfsr);
  end

  // Monitor: pop one expectation per strobe, check contents, width and stability
  initial begin : monitor
    exp_t cur;
    bit   prev = 1'b0;
    bit   have = 1'b0;
    bit   stable = 1'b1;
    int   width = 0;
    forever begin
      @(negedge clk_100mhz);
      if (bus.pos_valid && !prev) begin
        n_rises++;
        width  = 1;
        stable = 1'b1;
        check("strobe_expected", int'(exp_q.size() != 0), 1);
        have = (exp_q.size() != 0);
        if (have) begin
          cur = exp_q.pop_front();
          check("p1_pos", bus.player1_pos_x, cur.p1);
          check("p2_pos", bus.player2_pos_x, cur.p2);
          check("active_player", bus.active_player, cur.act);
          check("dice_value", bus.dice_value, cur.dice);
        end
      end else if (bus.pos_valid && prev) begin
        width++;
        if (have && (bus.player1_pos_x != cur.p1 || bus.player2_pos_x != cur.p2 ||
                     bus.active_player != cur.act)) stable = 1'b0;
      end else if (!bus.pos_valid && prev) begin
        if (abort_ok) begin
          abort_ok = 1'b0;
        end else begin
          check("pos_valid_width", width, 4);
          if (have) check("pos_stable", int'(stable), 1);
        end
        have = 1'b0;
      end
      prev = bus.pos_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset();
    btn_roll  = 1'b0;
    turn_done = 1'b0;
    btn_reset = 1'b1;
    tick(3);
    btn_reset = 1'b0;
    tick(2);
  endtask

  task automatic press();
    btn_roll = 1'b1;
    tick(8);
    btn_roll = 1'b0;
    tick(8);
  endtask

  task automatic pulse_done();
    turn_done = 1'b1;
    tick(4);
    turn_done = 1'b0;
    tick(6);
  endtask

  // Wait in IDLE until a press now would draw the wanted die (ROLL sits 7 clocks after the press), then queue the expectation
  task automatic arm_roll(input logic [1:0] dice, input int p1, input int p2,
                          input logic act, output bit found);
    logic [7:0] v;
    exp_t       e;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v = m_lfsr;
      for (int k = 0; k < 7; k++) v = tb_step(v);
      if (2'(v % 8'd3) + 2'd1 == dice) begin
        e.p1   = 10'(p1);
        e.p2   = 10'(p2);
        e.act  = act;
        e.dice = dice;
        exp_q.push_back(e);
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check("roll_slot_found", int'(found), 1);
  endtask

  task automatic roll(input logic [1:0] dice, input int p1, input int p2, input logic act);
    bit f;
    arm_roll(dice, p1, p2, act, f);
    if (f) press();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_p1"}, bus.player1_pos_x, 20);
    check({tag, "_p2"}, bus.player2_pos_x, 20);
    check({tag, "_active"}, bus.active_player, 0);
    check({tag, "_pos_valid"}, bus.pos_valid, 0);
    check({tag, "_dice"}, bus.dice_value, 1);
    check({tag, "_game_over"}, bus.game_over, 0);
    check({tag, "_winner"}, bus.winner, 0);
  endtask

  // Race table after the opening turns: die, P1, P2, mover
  localparam int c_n_turns = 7;
  int t_dice[c_n_turns] = '{3, 1, 3, 1, 1, 1, 3};
  int t_p1  [c_n_turns] = '{320, 320, 500, 500, 560, 560, 620};
  int t_p2  [c_n_turns] = '{80, 140, 140, 200, 200, 260, 260};
  int t_act [c_n_turns] = '{0, 1, 0, 1, 0, 1, 0};

  initial begin : stimulus
    int r0;
    bit f;
    #2;
    do_reset();
    reset_checks("reset");

    // turn_done while IDLE must not advance the turn
    pulse_done();
    check("idle_done_active", bus.active_player, 0);
    check("idle_done_no_strobe", n_rises, 0);

    // P1 rolls a 2: 20 + 120
    roll(2'd2, 140, 20, 1'b0);

    // Roll press during WAIT_DONE is dropped
    r0 = n_rises;
    press();
    check("wait_press_no_strobe", n_rises - r0, 0);
    check("wait_press_active", bus.active_player, 0);

    pulse_done();
    check("handover_to_p2", bus.active_player, 1);

    // P2 rolls a 1: only P2 moves
    roll(2'd1, 140, 80, 1'b1);
    pulse_done();
    check("handover_to_p1", bus.active_player, 0);

    for (int i = 0; i < c_n_turns; i++) begin
      roll(2'(t_dice[i]), t_p1[i], t_p2[i], 1'(t_act[i]));
      pulse_done();
      if (i < c_n_turns - 1) check("turn_handover", bus.active_player, 1 - t_act[i]);
    end

    // 560 + 180 clamped to 620 ends the game for P1
    check("game_over_set", bus.game_over, 1);
    check("winner_p1", bus.winner, 0);
    check("final_active", bus.active_player, 0);

    r0 = n_rises;
    press();
    check("game_over_no_strobe", n_rises - r0, 0);
    check("game_over_held", bus.game_over, 1);
    check("game_over_p1_held", bus.player1_pos_x, 620);
    check("game_over_p2_held", bus.player2_pos_x, 260);

    do_reset();
    reset_checks("rereset");

    // Reset in the middle of the strobe
    arm_roll(2'd2, 140, 20, 1'b0, f);
    if (f) begin
      btn_roll = 1'b1;
      tick(9);
      check("abort_pos_valid_high", bus.pos_valid, 1);
      abort_ok  = 1'b1;
      btn_reset = 1'b1;
      #1;
      check("abort_pos_valid_dropped", bus.pos_valid, 0);
      btn_roll = 1'b0;
      tick(3);
      btn_reset = 1'b0;
      r0 = n_rises;
      tick(12);
      check("abort_no_residual", n_rises - r0, 0);
      check("abort_p1_reset", bus.player1_pos_x, 20);
      check("abort_active_reset", bus.active_player, 0);
    end

`ifdef TURN_TIMEOUT_EN
    // No turn_done: 50 WAIT_DONE cycles, one NEXT cycle, then P2 holds the turn
    roll(2'd2, 140, 20, 1'b0);
    tick(45);
    check("timeout_not_early", bus.active_player, 0);
    tick(2);
    check("timeout_handover", bus.active_player, 1);
    roll(2'd1, 140, 80, 1'b1);
`endif

    tick(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
